// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum_accumulator block.
package sum_acc_pkg;

  // Block FSM: gathering samples, or presenting a closed block result
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int COUNT_N_DEF = 8;

endpackage

// File: rtl/sum_acc_add.sv
// Accumulator adder: ACC_W-wide add with carry-out.
// Optional macro SUM_ACC_SAT_EN: when defined, a carry clamps the sum to
// all-ones instead of wrapping modulo 2^ACC_W.
module sum_acc_add
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

`ifdef SUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [ACC_W:0] raw;

  // Clamp to full scale on carry when saturation is built in, else wrap
  function automatic logic [ACC_W-1:0] sat_sel(input logic c, input logic [ACC_W-1:0] w);
    return (SAT && c) ? {ACC_W{1'b1}} : w;
  endfunction

  // One-bit-wider add exposes the carry out of bit ACC_W-1
  always_comb begin
    raw   = {1'b0, acc} + {1'b0, addend};
    carry = raw[ACC_W];
    sum   = sat_sel(raw[ACC_W], raw[ACC_W-1:0]);
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums blocks of COUNT_N unsigned samples (adder16 sums)
// into an ACC_W accumulator and presents each block result through a
// valid/ready handshake. A block closes on the COUNT_N-th accept or on a
// flush with at least one sample in it. Sticky out_ovf flags a carry.
// Optional macro SUM_ACC_SAT_EN: saturate the accumulator instead of wrapping.
// ACC_W must be >= DATA_W and COUNT_N must be >= 1.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  parameter  int COUNT_N = COUNT_N_DEF,
  localparam int CNT_W   = $clog2(COUNT_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic              accept;
  logic              close;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;

  sum_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc),
    .addend (ACC_W'(in_data)),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // Input side is open only while gathering; no bypass from HOLD
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  // Post-accept values, and the close decision (count reached or flush of a non-empty block)
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (accept) begin
      acc_nxt = add_sum;
      cnt_nxt = cnt + CNT_W'(1);
      ovf_nxt = ovf | add_carry;
    end
    close = (state == ACCUM) &&
            ((accept && (cnt == CNT_W'(COUNT_N - 1))) ||
             (flush && ((cnt != '0) || accept)));
  end

  // Block FSM and output valid: close moves to HOLD, handshake returns to ACCUM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (close) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Running accumulator, sample counter and sticky overflow; cleared on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ACCUM) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end else if (out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  // Result registers capture post-accept values on close and hold until the next close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_acc   <= acc_nxt;
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
    end
  end

endmodule
